// File: rtl/nvme_host_lite_master_if.sv
// Request/response stream plus AXI4-Lite master bundle for nvme_host_lite_master.
// The master modport is the bridge side; the slave modport is the requester/AXI-slave side.
interface nvme_host_lite_master_if #(
   parameter int unsigned ADDR_BITS = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_BITS-1:0] req_addr;
   logic [31:0]          req_wdata;
   logic [3:0]           req_wstrb;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_write;
   logic [31:0]          rsp_rdata;
   logic [1:0]           rsp_resp;
   logic                 rsp_timeout;
   logic [ADDR_BITS-1:0] m_axi_awaddr;
   logic                 m_axi_awvalid;
   logic                 m_axi_awready;
   logic [31:0]          m_axi_wdata;
   logic [3:0]           m_axi_wstrb;
   logic                 m_axi_wvalid;
   logic                 m_axi_wready;
   logic [1:0]           m_axi_bresp;
   logic                 m_axi_bvalid;
   logic                 m_axi_bready;
   logic [ADDR_BITS-1:0] m_axi_araddr;
   logic                 m_axi_arvalid;
   logic                 m_axi_arready;
   logic [31:0]          m_axi_rdata;
   logic [1:0]           m_axi_rresp;
   logic                 m_axi_rvalid;
   logic                 m_axi_rready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
      output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
      input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
   );
endinterface

// File: rtl/nvme_host_lite_master.sv
// Single-outstanding request/response to AXI4-Lite master bridge feeding the NVMe host slave.
// Optional watchdog abort compiled in with NVME_LITE_MASTER_TIMEOUT_EN.
module nvme_host_lite_master #(
   parameter int unsigned ADDR_BITS      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                     axi_aclk,
   input logic                     axi_aresetn,
   nvme_host_lite_master_if.master bus
);

   typedef enum logic [2:0] {StIdle, StWrAd, StWrB, StRdA, StRdR, StRsp} state_e;

`ifdef NVME_LITE_MASTER_TIMEOUT_EN
   // Idle and response states soak up stray B/R beats left behind by an abort.
   localparam logic IdleReady = 1'b1;
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_d, cnt_q;
   logic        rsp_timeout_d, rsp_timeout_q;
`else
   localparam logic IdleReady = 1'b0;
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

   state_e               state_d, state_q;
   logic                 req_ready_d, req_ready_q;
   logic                 awvalid_d, awvalid_q, wvalid_d, wvalid_q, bready_d, bready_q;
   logic                 arvalid_d, arvalid_q, rready_d, rready_q;
   logic                 aw_done_d, aw_done_q, w_done_d, w_done_q;
   logic [ADDR_BITS-1:0] addr_d, addr_q;
   logic [31:0]          wdata_d, wdata_q;
   logic [3:0]           wstrb_d, wstrb_q;
   logic                 write_d, write_q;
   logic                 rsp_valid_d, rsp_valid_q;
   logic                 rsp_write_d, rsp_write_q;
   logic [31:0]          rsp_rdata_d, rsp_rdata_q;
   logic [1:0]           rsp_resp_d, rsp_resp_q;
   logic                 accept;

   assign accept = (state_q == StIdle) && bus.req_valid && req_ready_q;

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      write_d     = write_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
      cnt_d         = cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      unique case (state_q)
         StIdle: begin
            req_ready_d = 1'b1;
            bready_d    = IdleReady;
            rready_d    = IdleReady;
            if (accept) begin
               req_ready_d = 1'b0;
               bready_d    = 1'b0;
               rready_d    = 1'b0;
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               wstrb_d     = bus.req_wstrb;
               write_d     = bus.req_write;
               if (bus.req_write) begin
                  state_d   = StWrAd;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = StRdA;
                  arvalid_d = 1'b1;
               end
            end
         end
         StWrAd: begin
            // AW and W complete independently; B waits for both.
            if (awvalid_q && bus.m_axi_awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && bus.m_axi_wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d  = StWrB;
               bready_d = 1'b1;
            end
         end
         StWrB: begin
            if (bus.m_axi_bvalid && bready_q) begin
               bready_d    = IdleReady;
               rready_d    = IdleReady;
               state_d     = StRsp;
               rsp_valid_d = 1'b1;
               rsp_write_d = write_q;
               rsp_rdata_d = '0;
               rsp_resp_d  = bus.m_axi_bresp;
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
            end
         end
         StRdA: begin
            if (arvalid_q && bus.m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdR;
            end
         end
         StRdR: begin
            if (bus.m_axi_rvalid && rready_q) begin
               bready_d    = IdleReady;
               rready_d    = IdleReady;
               state_d     = StRsp;
               rsp_valid_d = 1'b1;
               rsp_write_d = write_q;
               rsp_rdata_d = bus.m_axi_rdata;
               rsp_resp_d  = bus.m_axi_rresp;
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
            end
         end
         StRsp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
      if (accept) begin
         cnt_d = '0;
      end else if (state_q inside {StWrAd, StWrB, StRdA, StRdR}) begin
         cnt_d = cnt_q + 16'd1;
         // Abort overrides any handshake in the same cycle.
         if (cnt_q == TimeoutLast) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = IdleReady;
            rready_d      = IdleReady;
            state_d       = StRsp;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = write_q;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         write_q     <= write_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_write     = rsp_write_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.rsp_resp      = rsp_resp_q;
   assign bus.m_axi_awaddr  = addr_q;
   assign bus.m_axi_awvalid = awvalid_q;
   assign bus.m_axi_wdata   = wdata_q;
   assign bus.m_axi_wstrb   = wstrb_q;
   assign bus.m_axi_wvalid  = wvalid_q;
   assign bus.m_axi_bready  = bready_q;
   assign bus.m_axi_araddr  = addr_q;
   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_rready  = rready_q;
`ifdef NVME_LITE_MASTER_TIMEOUT_EN
   assign bus.rsp_timeout = rsp_timeout_q;
`else
   assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nvme_host_lite_master.sv
// Directed bench for nvme_host_lite_master: delay-configurable AXI-Lite slave plus a
// response scoreboard. Define NVME_LITE_MASTER_TIMEOUT_EN to add the watchdog scenario.
module tb_nvme_host_lite_master;
   localparam int unsigned AW = 32;

   typedef struct packed {
      logic        w;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        to;
   } rsp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   nvme_host_lite_master_if #(.ADDR_BITS(AW)) ifc ();

   nvme_host_lite_master #(.ADDR_BITS(AW), .TIMEOUT_CYCLES(16)) dut (
      .axi_aclk   (clk),
      .axi_aresetn(rstn),
      .bus        (ifc)
   );

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   rsp_t exp_q[$];

   // Slave configuration
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic ar_never = 1'b0, force_rvalid = 1'b0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = '0;

   // Slave state and statistics
   int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_cnt = 0;
   int r_hs_cyc = 0;
   logic [31:0] last_awaddr = '0, last_wdata = '0;
   logic [3:0]  last_wstrb = '0;
   logic aw_now, w_now;

   assign aw_now = ifc.m_axi_awvalid && ifc.m_axi_awready;
   assign w_now  = ifc.m_axi_wvalid && ifc.m_axi_wready;
   assign ifc.m_axi_awready = ifc.m_axi_awvalid && (aw_wait >= aw_dly);
   assign ifc.m_axi_wready  = ifc.m_axi_wvalid && (w_wait >= w_dly);
   assign ifc.m_axi_arready = ifc.m_axi_arvalid && !ar_never && (ar_wait >= ar_dly);
   assign ifc.m_axi_bvalid  = b_pend && (b_wait >= b_dly);
   assign ifc.m_axi_rvalid  = force_rvalid || (r_pend && (r_wait >= r_dly));
   assign ifc.m_axi_bresp   = bresp_cfg;
   assign ifc.m_axi_rresp   = rresp_cfg;
   assign ifc.m_axi_rdata   = rdata_cfg;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ifc.rsp_valid && ifc.rsp_ready) rsp_cnt <= rsp_cnt + 1;
      if (!rstn) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      end else begin
         if (aw_now) begin
            aw_hs <= aw_hs + 1; aw_got <= 1'b1; aw_wait <= 0; last_awaddr <= ifc.m_axi_awaddr;
         end else if (ifc.m_axi_awvalid) aw_wait <= aw_wait + 1;
         if (w_now) begin
            w_hs <= w_hs + 1; w_got <= 1'b1; w_wait <= 0;
            last_wdata <= ifc.m_axi_wdata; last_wstrb <= ifc.m_axi_wstrb;
         end else if (ifc.m_axi_wvalid) w_wait <= w_wait + 1;
         if ((aw_got || aw_now) && (w_got || w_now) && !b_pend) begin
            b_pend <= 1'b1; b_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (b_pend) begin
            if (ifc.m_axi_bvalid && ifc.m_axi_bready) begin
               b_pend <= 1'b0; b_hs <= b_hs + 1;
            end else b_wait <= b_wait + 1;
         end
         if (ifc.m_axi_arvalid && ifc.m_axi_arready) begin
            ar_hs <= ar_hs + 1; ar_wait <= 0; r_pend <= 1'b1; r_wait <= 0;
         end else if (ifc.m_axi_arvalid) ar_wait <= ar_wait + 1;
         if (r_pend) begin
            if (ifc.m_axi_rvalid && ifc.m_axi_rready) begin
               r_pend <= 1'b0; r_hs <= r_hs + 1; r_hs_cyc <= cyc;
            end else r_wait <= r_wait + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({ifc.req_ready, ifc.rsp_valid, ifc.rsp_write, ifc.rsp_rdata, ifc.rsp_resp,
                  ifc.rsp_timeout, ifc.m_axi_awvalid, ifc.m_axi_wvalid, ifc.m_axi_bready,
                  ifc.m_axi_arvalid, ifc.m_axi_rready});
   endfunction

   function automatic rsp_t obs_rsp();
      return {ifc.rsp_write, ifc.rsp_rdata, ifc.rsp_resp, ifc.rsp_timeout};
   endfunction

   // Returns at the negedge of the cycle after acceptance; acc = cycle of acceptance.
   task automatic send_req(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb, output int acc);
      int n;
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_write = wr; ifc.req_addr = addr;
      ifc.req_wdata = wd;   ifc.req_wstrb = strb;
      n = 0;
      while (!ifc.req_ready && n < 50) begin
         @(negedge clk); n++;
      end
      chk({tag, "_req_ready"}, 64'(ifc.req_ready), 64'd1);
      acc = cyc;
      @(negedge clk);
      ifc.req_valid = 1'b0;
   endtask

   // Waits for rsp_valid, pops the scoreboard and compares the response fields.
   task automatic wait_valid(input string tag, output int rcyc, output rsp_t e);
      int n;
      n = 0;
      while (!ifc.rsp_valid && n < 200) begin
         @(negedge clk); n++;
      end
      rcyc = cyc;
      chk({tag, "_rsp_valid"}, 64'(ifc.rsp_valid), 64'd1);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_rsp_fields"}, 64'(obs_rsp()), 64'(e));
   endtask

   // Holds rsp_ready low for hold cycles checking stability, then consumes the response.
   task automatic finish_rsp(input string tag, input int hold, input rsp_t e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_fields"}, 64'({ifc.rsp_valid, obs_rsp()}), 64'({1'b1, e}));
         chk({tag, "_hold_req_ready"}, 64'(ifc.req_ready), 64'd0);
      end
      ifc.rsp_ready = 1'b1;
      @(negedge clk);
      ifc.rsp_ready = 1'b0;
      chk({tag, "_rsp_done"}, 64'({ifc.rsp_valid, ifc.req_ready}), 64'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int acc, rcyc, a0, w0, b0, r0, ar0;
      rsp_t e;
      logic [1:0] aw_d_tab [3];
      logic [1:0] w_d_tab [3];
      ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_addr = '0;
      ifc.req_wdata = '0;   ifc.req_wstrb = '0;   ifc.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs_vec(), 64'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("reset_release_req_ready", 64'(ifc.req_ready), 64'd1);

      // 1: minimum-latency write
      exp_q.push_back('{w: 1'b1, rdata: 32'h0, resp: 2'b00, to: 1'b0});
      send_req("t1", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
      chk("t1_aw_w", 64'({ifc.m_axi_awvalid, ifc.m_axi_wvalid, ifc.m_axi_awaddr}),
          64'({2'b11, 32'h10}));
      chk("t1_wdata", 64'({ifc.m_axi_wdata, ifc.m_axi_wstrb}), 64'({32'hDEADBEEF, 4'hF}));
      wait_valid("t1", rcyc, e);
      chk("t1_latency", 64'(rcyc - acc), 64'd3);
      finish_rsp("t1", 0, e);

      // 2: read with 5 wait cycles on rvalid
      r_dly = 5; rdata_cfg = 32'h12345678;
      exp_q.push_back('{w: 1'b0, rdata: 32'h12345678, resp: 2'b00, to: 1'b0});
      send_req("t2", 1'b0, 32'h04, 32'h0, 4'h0, acc);
      chk("t2_ar", 64'({ifc.m_axi_arvalid, ifc.m_axi_araddr}), 64'({1'b1, 32'h04}));
      wait_valid("t2", rcyc, e);
      chk("t2_after_r_hs", 64'(rcyc - r_hs_cyc), 64'd1);
      chk("t2_latency", 64'(rcyc - acc), 64'd8);
      finish_rsp("t2", 0, e);
      r_dly = 0;

      // 3: W before AW, AW before W, both together
      aw_d_tab[0] = 2'd3; w_d_tab[0] = 2'd0;
      aw_d_tab[1] = 2'd0; w_d_tab[1] = 2'd3;
      aw_d_tab[2] = 2'd0; w_d_tab[2] = 2'd0;
      for (int k = 0; k < 3; k++) begin
         aw_dly = int'(aw_d_tab[k]); w_dly = int'(w_d_tab[k]);
         a0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = rsp_cnt;
         exp_q.push_back('{w: 1'b1, rdata: 32'h0, resp: 2'b00, to: 1'b0});
         send_req("t3", 1'b1, 32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'h3, acc);
         wait_valid("t3", rcyc, e);
         chk("t3_latency", 64'(rcyc - acc), (k == 2) ? 64'd3 : 64'd6);
         finish_rsp("t3", 0, e);
         chk("t3_hs_counts", 64'({8'(aw_hs - a0), 8'(w_hs - w0), 8'(b_hs - b0), 8'(rsp_cnt - r0)}),
             64'h01010101);
         chk("t3_axi_data", 64'({last_awaddr, last_wdata}),
             {32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k)});
         chk("t3_wstrb", 64'(last_wstrb), 64'h3);
      end
      aw_dly = 0; w_dly = 0;

      // 4: SLVERR response held while rsp_ready stays low
      bresp_cfg = 2'b10;
      exp_q.push_back('{w: 1'b1, rdata: 32'h0, resp: 2'b10, to: 1'b0});
      send_req("t4", 1'b1, 32'h20, 32'h55AA55AA, 4'hC, acc);
      wait_valid("t4", rcyc, e);
      finish_rsp("t4", 4, e);
      bresp_cfg = 2'b00;

`ifdef NVME_LITE_MASTER_TIMEOUT_EN
      // 5: watchdog abort, then a late R beat absorbed in idle
      ar_never = 1'b1; ar0 = ar_hs;
      exp_q.push_back('{w: 1'b0, rdata: 32'h0, resp: 2'b10, to: 1'b1});
      send_req("t5", 1'b0, 32'h30, 32'h0, 4'h0, acc);
      wait_valid("t5", rcyc, e);
      chk("t5_latency", 64'(rcyc - acc), 64'd17);
      chk("t5_arvalid_dropped", 64'(ifc.m_axi_arvalid), 64'd0);
      chk("t5_no_ar_hs", 64'(ar_hs - ar0), 64'd0);
      finish_rsp("t5", 0, e);
      ar_never = 1'b0;
      r0 = rsp_cnt;
      force_rvalid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t5_late_r", 64'({ifc.m_axi_rready, ifc.rsp_valid, ifc.req_ready}), 64'b101);
      end
      force_rvalid = 1'b0;
      @(negedge clk);
      chk("t5_no_second_rsp", 64'({ifc.rsp_valid, 8'(rsp_cnt - r0)}), 64'd0);
`endif

      // 6: reset while waiting for B, then a clean read
      b_dly = 8;
      send_req("t6", 1'b1, 32'h40, 32'h0BADF00D, 4'hF, acc);
      @(negedge clk);
      chk("t6_in_wr_b", 64'({ifc.m_axi_bready, ifc.m_axi_bvalid}), 64'b10);
      rstn = 1'b0;
      @(negedge clk);
      chk("t6_reset_outputs", outs_vec(), 64'd0);
      rstn = 1'b1; b_dly = 0;
      @(negedge clk);
      chk("t6_req_ready", 64'(ifc.req_ready), 64'd1);
      rdata_cfg = 32'hA5A5_5A5A;
      exp_q.push_back('{w: 1'b0, rdata: 32'hA5A5_5A5A, resp: 2'b00, to: 1'b0});
      send_req("t6b", 1'b0, 32'h08, 32'h0, 4'h0, acc);
      wait_valid("t6b", rcyc, e);
      chk("t6b_latency", 64'(rcyc - acc), 64'd3);
      finish_rsp("t6b", 1, e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
